// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM encoding, iteration count and operand magnitude helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 5;

  // Magnitude only for signed operands; |0x80000000| still fits as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple-carry adder used for one partial-product addition per cycle.
module adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] z,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign z[gi]         = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = carry[32];

endmodule

// File: rtl/mult_32_seq.sv
// Sequential 32x32 shift-and-add multiplier producing {hi, lo}; signed
// operands are handled as magnitudes with a final 64-bit negate.
module mult_32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_z;
  logic               add_cout;

  assign add_y = acc[0] ? mcand : '0;

  adder_32 u_adder (
    .x    (acc[2*WIDTH-1:WIDTH]),
    .y    (add_y),
    .cin  (1'b0),
    .z    (add_z),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag32(a, is_signed);
            neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= {{WIDTH{1'b0}}, mag32(b, is_signed)};
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          // Carry-out becomes the new MSB so products >= 2^63 stay exact.
          acc <= {add_cout, add_z, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MULT_ITER - 1)) state <= SIGN;
        end
        SIGN: begin
          if (neg) acc <= ~acc + 64'd1;
          state <= DONE;
        end
        DONE: begin
          hi    <= acc[2*WIDTH-1:WIDTH];
          lo    <= acc[WIDTH-1:0];
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_32_seq.sv
// Scoreboard bench for mult_32_seq: directed vectors push expected products,
// a monitor pops and checks value and latency on every done pulse.
module tb_mult_32_seq;

  typedef struct {
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          accept_cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  mult_32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_hi"}, hi, e.exp_hi);
        chk({e.name, "_lo"}, lo, e.exp_lo);
        chk({e.name, "_latency"}, 32'(cyc - e.accept_cyc), 32'd34);
        $display("txn %s: hi=0x%08h lo=0x%08h latency=%0d", e.name, hi, lo, cyc - e.accept_cyc);
      end
    end
  end

  // Start a multiply from IDLE; optionally record the expected product.
  task automatic issue(input string name, input logic sgn, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ehi,
                       input logic [31:0] elo, input bit expect_it);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; is_signed = sgn; start = 1'b1;
    if (expect_it) begin
      e.exp_hi = ehi; e.exp_lo = elo; e.accept_cyc = cyc + 1; e.name = name;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
      q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    issue("u_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000000F, 1'b1);
    wait_idle("u_3x5");
    issue("u_ffxff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    wait_idle("u_ffxff");
    issue("s_m7x3", 1'b1, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
    wait_idle("s_m7x3");
    issue("s_minxmin", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b1);
    wait_idle("s_minxmin");
    issue("s_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b1);
    wait_idle("s_m1xm1");
    issue("u_ffx2", 1'b0, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    wait_idle("u_ffx2");
    issue("s_m1x2", 1'b1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
    wait_idle("s_m1x2");
    issue("s_5xm4", 1'b1, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b1);
    wait_idle("s_5xm4");
    issue("u_64kx64k", 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h0, 1'b1);
    wait_idle("u_64kx64k");

    // Reset mid-CALC: outputs clear, no done may follow.
    issue("rst_mid", 1'b0, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (45) @(negedge clk);
    chk("rst_mid_idle_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_lo_held", lo, 32'd0);

    // Start raised again while busy must be ignored.
    issue("busy_start", 1'b0, 32'd7, 32'd9, 32'h0, 32'h0000003F, 1'b1);
    repeat (2) @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (40) @(negedge clk);
    chk("busy_start_lo_held", lo, 32'h0000003F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_32_seq.md
# mult_32_seq

Sequential 32×32 shift-and-add multiplier for the MIPS datapath's MULT/MULTU path, producing the 64-bit {HI, LO} product. It sits directly upstream of the 32-bit ripple adder `adder_32`: each cycle it feeds that adder one partial-product addition and consumes the sum and carry-out. It runs beside the ALU and writes the HI/LO register pair when `done` pulses.

## Interface
- `WIDTH`, 32: operand width. Fixed at 32 and matched to `adder_32`; other values are unsupported.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `is_signed`  in  1  1 = MULT (two's complement), 0 = MULTU.
- `a`  in  32  multiplicand; sampled with `start`.
- `b`  in  32  multiplier; sampled with `start`.
- `busy`  out  1  high from the cycle after start is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  32  upper product word; held until the next accepted start.
- `lo`  out  32  lower product word; held until the next accepted start.

## Operation
- **States:** IDLE, CALC, SIGN, DONE.
- **IDLE, start=1:**
  - Latch `mcand = |a|` and `neg = is_signed & (a[31]^b[31])`.
  - Load `acc = {32'h0, |b|}`.
  - Set `cnt = 0`, then go to CALC.
  - Magnitudes are taken only when `is_signed=1`, otherwise the raw value is used. |0x80000000| = 0x80000000, which fits unsigned.
- **CALC, per cycle:**
  - `adder_32` gets `x = acc[63:32]`, `y = acc[0] ? mcand : 0`, `cin = 0`.
  - Update `acc <= {cout, z, acc[31:1]}`, a 65→64-bit right shift that keeps the carry.
  - `cnt` increments; after 32 iterations (`cnt` == 31 at the edge) go to SIGN.
- **SIGN:** if `neg`, `acc <= ~acc + 1` (64-bit); otherwise hold. Go to DONE.
- **DONE:**
  - `hi = acc[63:32]`, `lo = acc[31:0]`, `done = 1`, `busy = 1`.
  - Next state is IDLE.
- **start outside IDLE** is ignored, with no queuing.
- **start in the DONE cycle** is ignored; it is first sampled in the following IDLE cycle.
- **Reset (any state, including mid-CALC):**
  - State goes to IDLE, `acc`/`hi`/`lo` = 0, `busy` = 0, `done` = 0, `cnt` = 0.
  - No partial result is exposed.
- **Product width:** the unsigned product is exact in 64 bits. The carry from `adder_32` must be retained every iteration, or products ≥ 2^63 are corrupted.

## Timing
- start accepted at edge T: CALC occupies edges T+1..T+32, SIGN is T+33, DONE (the `done` pulse) is T+34.
- Fixed latency of 34 cycles, independent of operand values and sign.
- Throughput: one multiply per 35 cycles when start is held high continuously.
- `busy` rises at T+1 and falls at T+35.
- `hi`/`lo` change only on the DONE transition or on reset.
- The critical path is the 32-bit ripple in `adder_32` plus the shift mux, within one cycle. The SIGN-cycle negate is a separate 64-bit path and must not be chained onto that ripple.

## Structure
- **Shared package `mult_pkg`:** state encoding (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3), `MULT_ITER = 32`, `CNT_W = 5`.
- **Sub-module:** one `adder_32` instance for the per-iteration add.
- **Negate and abs:** done in local logic, not in a second adder instance.
- **Registered signals:** all outputs are registered; `busy` and `done` decode from state only.

## Test plan
- Unsigned `a=3`, `b=5` → `done` at T+34, `hi=0x00000000`, `lo=0x0000000F`.
- Unsigned `a=b=0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`. This checks carry retention.
- Signed `a=0xFFFFFFF9` (−7), `b=3` → `hi=0xFFFFFFFF`, `lo=0xFFFFFFEB`.
- Signed `a=b=0x80000000` → `hi=0x40000000`, `lo=0x00000000`.
- Signed `a=b=0xFFFFFFFF` (−1·−1) → `hi=0`, `lo=1`.
- Reset and start-while-busy, in two parts:
  - Start `a=7`, `b=9` and pulse `rst_n` low at T+10 → outputs 0, `busy`=0, no `done`.
  - Then start `a=7`, `b=9` and raise start again at T+5 with `a=2`, `b=2` → single `done` at T+34 with `lo=0x3F`.
